// File: rtl/std_mem_d1_reader.sv
// Streams COUNT words from a single-port combinational-read memory, starting at START_ADDR.
// Optional STD_MEM_D1_READER_CHECK_EN enables a simulation $error on out-of-range go requests.
module std_mem_d1_reader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] start_addr,
  input  logic [IDX_SIZE:0]   count,
  output logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    read_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [IDX_SIZE:0]   SIZE_W   = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

  state_t              state;
  logic [IDX_SIZE-1:0] ptr;
  logic [IDX_SIZE:0]   rem;
  logic                handshake;

  // Wraps at SIZE-1 rather than at the power-of-two boundary.
  function automatic logic [IDX_SIZE-1:0] next_ptr(input logic [IDX_SIZE-1:0] p);
    return (p == LAST_IDX) ? '0 : p + IDX_SIZE'(1);
  endfunction

  function automatic logic [IDX_SIZE-1:0] clamp_addr(input logic [IDX_SIZE-1:0] a);
    return ({1'b0, a} >= SIZE_W) ? '0 : a;
  endfunction

  function automatic logic [IDX_SIZE:0] clamp_count(input logic [IDX_SIZE:0] c);
    return (c > SIZE_W) ? SIZE_W : c;
  endfunction

  assign handshake = out_valid & out_ready;
  assign addr0     = (state == FETCH || state == SEND) ? ptr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      rem       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            ptr  <= clamp_addr(start_addr);
            rem  <= clamp_count(count);
            busy <= 1'b1;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          out_data  <= read_data;
          out_valid <= 1'b1;
          ptr       <= next_ptr(ptr);
          rem       <= rem - (IDX_SIZE+1)'(1);
          state     <= SEND;
        end
        SEND: begin
          // rem counts words not yet loaded; the word on out_data is already accounted for.
          if (handshake) begin
            if (rem != '0) begin
              out_data <= read_data;
              ptr      <= next_ptr(ptr);
              rem      <= rem - (IDX_SIZE+1)'(1);
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STD_MEM_D1_READER_CHECK_EN
  always @(posedge clk) begin
    if (!reset && state == IDLE && go && ((count > SIZE_W) || ({1'b0, start_addr} >= SIZE_W)))
      $error("std_mem_d1_reader: out-of-range request count=%0d start_addr=%0d", count, start_addr);
  end
`endif

endmodule

// File: tb/tb_std_mem_d1_reader.sv
// Table-driven bench for std_mem_d1_reader with a mem[i]=i*0x11 memory model.
module tb_std_mem_d1_reader;

  logic        clk = 1'b0;
  logic        reset, go, out_ready;
  logic [3:0]  start_addr, addr0;
  logic [4:0]  count;
  logic [31:0] read_data, out_data;
  logic        out_valid, busy, done;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  assign read_data = 32'(addr0) * 32'h11;

  std_mem_d1_reader #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut (
    .clk(clk), .reset(reset), .go(go), .start_addr(start_addr), .count(count),
    .addr0(addr0), .read_data(read_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  typedef struct {
    logic        rst;
    logic        go;
    logic [3:0]  sa;
    logic [4:0]  cnt;
    logic        rdy;
    logic        chk;
    logic        cd;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ea;
    logic        eb;
    logic        edn;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic g, input int sa, input int cnt, input logic rdy,
                     input logic chk, input logic cd, input logic ev, input logic [31:0] ed,
                     input int ea, input logic eb, input logic edn);
    vq.push_back('{rst, g, 4'(sa), 5'(cnt), rdy, chk, cd, ev, ed, 4'(ea), eb, edn});
  endtask

  task automatic idle_rec(input logic g, input int sa, input int cnt);
    add(0, g, sa, cnt, 1, 1, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic fetch_rec(input int a);
    add(0, 0, 0, 0, 1, 1, 0, 0, 32'h0, a, 1, 0);
  endtask

  task automatic send_rec(input logic [31:0] d, input int a, input logic rdy);
    add(0, 0, 0, 0, rdy, 1, 1, 1, d, a, 1, 0);
  endtask

  task automatic done_rec();
    add(0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 1, 1);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s rec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;

    // Reset and reset-state check
    add(1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 0, 0);

    // start 2, count 3, ready high
    idle_rec(1, 2, 3);
    fetch_rec(2);
    send_rec(32'h22, 3, 1);
    send_rec(32'h33, 4, 1);
    send_rec(32'h44, 5, 1);
    done_rec();
    idle_rec(0, 0, 0);

    // wrap from 15 to 0
    idle_rec(1, 14, 4);
    fetch_rec(14);
    send_rec(32'hEE, 15, 1);
    send_rec(32'hFF, 0, 1);
    send_rec(32'h00, 1, 1);
    send_rec(32'h11, 2, 1);
    done_rec();
    idle_rec(0, 0, 0);

    // back-pressure on cycles 3-5
    idle_rec(1, 2, 3);
    fetch_rec(2);
    send_rec(32'h22, 3, 1);
    send_rec(32'h33, 4, 0);
    send_rec(32'h33, 4, 0);
    send_rec(32'h33, 4, 0);
    send_rec(32'h33, 4, 1);
    send_rec(32'h44, 5, 1);
    done_rec();
    idle_rec(0, 0, 0);

    // count 0
    idle_rec(1, 3, 0);
    done_rec();
    idle_rec(0, 0, 0);

    // reset during a count=5 stream, handshake pending, then clean restart
    idle_rec(1, 0, 5);
    fetch_rec(0);
    send_rec(32'h00, 1, 1);
    add(1, 0, 0, 0, 1, 1, 1, 1, 32'h11, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 0, 0);
    idle_rec(0, 0, 0);
    idle_rec(1, 5, 2);
    fetch_rec(5);
    send_rec(32'h55, 6, 1);
    send_rec(32'h66, 7, 1);
    done_rec();
    idle_rec(0, 0, 0);

    // count 20 clamped to 16; a go while busy is ignored
    idle_rec(1, 0, 20);
    fetch_rec(0);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) add(0, 1, 9, 1, 1, 1, 1, 1, 32'(i) * 32'h11, (i + 1) % 16, 1, 0);
      else        send_rec(32'(i) * 32'h11, (i + 1) % 16, 1);
    end
    done_rec();
    idle_rec(0, 0, 0);
    idle_rec(0, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].chk) begin
        cmp("out_valid", i, 32'(out_valid), 32'(vq[i].ev));
        cmp("addr0",     i, 32'(addr0),     32'(vq[i].ea));
        cmp("busy",      i, 32'(busy),      32'(vq[i].eb));
        cmp("done",      i, 32'(done),      32'(vq[i].edn));
        if (vq[i].cd) cmp("out_data", i, out_data, vq[i].ed);
      end
      reset = vq[i].rst; go = vq[i].go; start_addr = vq[i].sa;
      count = vq[i].cnt; out_ready = vq[i].rdy;
      @(posedge clk); #1;
    end

    // reset asserted together with go: request must be dropped
    reset = 1'b1; go = 1'b1; start_addr = 4'd1; count = 5'd2;
    @(posedge clk); #1;
    reset = 1'b0; go = 1'b0;
    cmp("rst_go_busy",  -1, 32'(busy),      32'd0);
    cmp("rst_go_valid", -1, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    cmp("rst_go_busy2", -2, 32'(busy),      32'd0);
    cmp("rst_go_addr",  -2, 32'(addr0),     32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
